lsu_mem_master: RTL and testbench

- Load/store initiator that drives the core's DPI-backed data RAM port.
- Accepts one byte, half or word load/store from the execute stage over a valid/ready handshake.
- Formats address, data and byte mask for the RAM, holds the request for a fixed memory latency, then returns an aligned, extended load result or a misalignment error.
- Sits between the execute stage and the RAM model; single outstanding request.

---
 rtl/lsu_mem_master.sv | 167 ++++++++++++++++
 tb/tb_lsu_mem_master.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_mem_master.sv
// Load/store initiator: formats one byte/half/word access for the data RAM port,
// holds it for MEM_LATENCY cycles and returns an extended load result or a misalignment error.
module lsu_mem_master #(
    parameter int unsigned MEM_LATENCY = 1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_misalign,
    output logic        mem_valid,
    output logic        mem_write_enable,
    output logic [31:0] mem_write_addr,
    output logic [31:0] mem_write_data,
    output logic [3:0]  mem_write_mask,
    output logic [31:0] mem_read_addr,
    input  logic [31:0] mem_read_data
);

    localparam logic [3:0] LAT_M1 = 4'(MEM_LATENCY - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACCESS,
        S_RESP
    } state_t;

    state_t      r_state;
    logic [3:0]  r_cnt;
    logic        r_write;
    logic [1:0]  r_size;
    logic        r_unsigned;
    logic [1:0]  r_off;

    logic        r_req_ready;
    logic        r_resp_valid;
    logic [31:0] r_resp_rdata;
    logic        r_resp_misalign;
    logic        r_mem_valid;
    logic        r_mem_we;
    logic [31:0] r_mem_addr;
    logic [31:0] r_mem_wdata;
    logic [3:0]  r_mem_mask;

    logic [1:0]  w_off;
    logic        w_misalign;
    logic [3:0]  w_mask;
    logic [31:0] w_raw;
    logic [31:0] w_load;

    assign w_off      = req_addr[1:0];
    assign w_misalign = (req_size == 2'd3) ||
                        ((req_size == 2'd1) && w_off[0]) ||
                        ((req_size == 2'd2) && (w_off != 2'b00));
    assign w_raw      = mem_read_data >> {r_off, 3'b000};

    always_comb begin
        w_mask = 4'b1111;
        case (req_size)
            2'd0:    w_mask = 4'b0001 << w_off;
            2'd1:    w_mask = 4'b0011 << w_off;
            default: w_mask = 4'b1111;
        endcase
    end

    always_comb begin
        w_load = w_raw;
        case (r_size)
            2'd0:    w_load = {{24{~r_unsigned & w_raw[7]}}, w_raw[7:0]};
            2'd1:    w_load = {{16{~r_unsigned & w_raw[15]}}, w_raw[15:0]};
            default: w_load = w_raw;
        endcase
    end

    // The raw shifted word is extended as it is captured, so resp_rdata comes straight from a register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state         <= S_IDLE;
            r_cnt           <= '0;
            r_write         <= 1'b0;
            r_size          <= '0;
            r_unsigned      <= 1'b0;
            r_off           <= '0;
            r_req_ready     <= 1'b1;
            r_resp_valid    <= 1'b0;
            r_resp_rdata    <= '0;
            r_resp_misalign <= 1'b0;
            r_mem_valid     <= 1'b0;
            r_mem_we        <= 1'b0;
            r_mem_addr      <= '0;
            r_mem_wdata     <= '0;
            r_mem_mask      <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (req_valid && r_req_ready) begin
                        r_write     <= req_write;
                        r_size      <= req_size;
                        r_unsigned  <= req_unsigned;
                        r_off       <= w_off;
                        r_req_ready <= 1'b0;
                        if (w_misalign) begin
                            r_state         <= S_RESP;
                            r_resp_valid    <= 1'b1;
                            r_resp_misalign <= 1'b1;
                            r_resp_rdata    <= '0;
                        end else begin
                            r_state     <= S_ACCESS;
                            r_cnt       <= LAT_M1;
                            r_mem_valid <= 1'b1;
                            r_mem_we    <= req_write && (LAT_M1 == 4'd0);
                            r_mem_addr  <= {req_addr[31:2], 2'b00};
                            r_mem_wdata <= req_wdata << {w_off, 3'b000};
                            r_mem_mask  <= w_mask;
                        end
                    end
                end
                S_ACCESS: begin
                    if (r_cnt == 4'd0) begin
                        r_state         <= S_RESP;
                        r_mem_valid     <= 1'b0;
                        r_mem_we        <= 1'b0;
                        r_mem_addr      <= '0;
                        r_mem_wdata     <= '0;
                        r_mem_mask      <= '0;
                        r_resp_valid    <= 1'b1;
                        r_resp_misalign <= 1'b0;
                        r_resp_rdata    <= r_write ? '0 : w_load;
                    end else begin
                        r_cnt    <= r_cnt - 4'd1;
                        r_mem_we <= r_write && (r_cnt == 4'd1);
                    end
                end
                S_RESP: begin
                    r_state         <= S_IDLE;
                    r_resp_valid    <= 1'b0;
                    r_resp_rdata    <= '0;
                    r_resp_misalign <= 1'b0;
                    r_req_ready     <= 1'b1;
                end
                default: begin
                    r_state     <= S_IDLE;
                    r_req_ready <= 1'b1;
                end
            endcase
        end
    end

    assign req_ready        = r_req_ready;
    assign resp_valid       = r_resp_valid;
    assign resp_rdata       = r_resp_rdata;
    assign resp_misalign    = r_resp_misalign;
    assign mem_valid        = r_mem_valid;
    assign mem_write_enable = r_mem_we;
    assign mem_write_addr   = r_mem_addr;
    assign mem_read_addr    = r_mem_addr;
    assign mem_write_data   = r_mem_wdata;
    assign mem_write_mask   = r_mem_mask;

endmodule

// File: tb/tb_lsu_mem_master.sv
// Bench for lsu_mem_master: two instances (latency 1 and 4) against a byte-array
// reference memory, with directed vectors, a mid-access reset and random traffic.
module tb_lsu_mem_master;

    localparam int unsigned LAT0 = 1;
    localparam int unsigned LAT1 = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst           [2];
    logic        req_valid     [2];
    logic        req_ready     [2];
    logic        req_write     [2];
    logic [31:0] req_addr      [2];
    logic [31:0] req_wdata     [2];
    logic [1:0]  req_size      [2];
    logic        req_unsigned  [2];
    logic        resp_valid    [2];
    logic [31:0] resp_rdata    [2];
    logic        resp_misalign [2];
    logic        mem_valid     [2];
    logic        mem_we        [2];
    logic [31:0] mem_waddr     [2];
    logic [31:0] mem_wdata     [2];
    logic [3:0]  mem_mask      [2];
    logic [31:0] mem_raddr     [2];
    logic [31:0] mem_rdata     [2];

    lsu_mem_master #(.MEM_LATENCY(LAT0)) u_dut0 (
        .clock(clk), .reset(rst[0]), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
        .req_write(req_write[0]), .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
        .req_size(req_size[0]), .req_unsigned(req_unsigned[0]), .resp_valid(resp_valid[0]),
        .resp_rdata(resp_rdata[0]), .resp_misalign(resp_misalign[0]), .mem_valid(mem_valid[0]),
        .mem_write_enable(mem_we[0]), .mem_write_addr(mem_waddr[0]), .mem_write_data(mem_wdata[0]),
        .mem_write_mask(mem_mask[0]), .mem_read_addr(mem_raddr[0]), .mem_read_data(mem_rdata[0])
    );

    lsu_mem_master #(.MEM_LATENCY(LAT1)) u_dut1 (
        .clock(clk), .reset(rst[1]), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
        .req_write(req_write[1]), .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
        .req_size(req_size[1]), .req_unsigned(req_unsigned[1]), .resp_valid(resp_valid[1]),
        .resp_rdata(resp_rdata[1]), .resp_misalign(resp_misalign[1]), .mem_valid(mem_valid[1]),
        .mem_write_enable(mem_we[1]), .mem_write_addr(mem_waddr[1]), .mem_write_data(mem_wdata[1]),
        .mem_write_mask(mem_mask[1]), .mem_read_addr(mem_raddr[1]), .mem_read_data(mem_rdata[1])
    );

    // RAM model per instance: 16 words, combinational read, masked write on the clock edge.
    logic [31:0] ram [2][16];
    logic        pl_en = 1'b0;
    int          pl_d = 0;
    logic [3:0]  pl_w = '0;
    logic [31:0] pl_val = '0;

    assign mem_rdata[0] = mem_valid[0] ? ram[0][mem_raddr[0][5:2]] : 32'h0;
    assign mem_rdata[1] = mem_valid[1] ? ram[1][mem_raddr[1][5:2]] : 32'h0;

    always @(posedge clk) begin
        if (pl_en) ram[pl_d][pl_w] <= pl_val;
        for (int d = 0; d < 2; d++)
            if (mem_we[d])
                for (int b = 0; b < 4; b++)
                    if (mem_mask[d][b]) ram[d][mem_waddr[d][5:2]][8*b +: 8] <= mem_wdata[d][8*b +: 8];
    end

    // Reference memory as plain bytes, updated from request semantics only.
    logic [7:0] refm [2][64];

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic set_word(input int d, input int w, input logic [31:0] v);
        logic [31:0] wv;
        wv = w;
        @(negedge clk);
        pl_en = 1'b1; pl_d = d; pl_w = wv[3:0]; pl_val = v;
        @(posedge clk);
        #1 pl_en = 1'b0;
        for (int b = 0; b < 4; b++) refm[d][4*w + b] = v[8*b +: 8];
    endtask

    task automatic ref_txn(input int d, input logic wr, input logic [31:0] addr, input logic [31:0] wd,
                           input logic [1:0] sz, input logic uns,
                           output logic exp_mis, output logic [31:0] exp_rd);
        int nb;
        int base;
        longint v;
        logic [63:0] vb;
        nb = 1 << sz;
        base = int'(addr[5:0]);
        exp_mis = (sz == 2'd3) || ((addr % nb) != 0);
        exp_rd = 32'h0;
        if (!exp_mis) begin
            if (wr) begin
                for (int i = 0; i < nb; i++) refm[d][base + i] = 8'((wd >> (8*i)) & 32'hFF);
            end else begin
                v = 0;
                for (int i = 0; i < nb; i++) v += longint'(refm[d][base + i]) << (8*i);
                if (!uns && nb < 4 && v >= (longint'(1) << (8*nb - 1))) v -= (longint'(1) << (8*nb));
                vb = 64'(v);
                exp_rd = vb[31:0];
            end
        end
    endtask

    task automatic txn(input int d, input logic wr, input logic [31:0] addr, input logic [31:0] wd,
                       input logic [1:0] sz, input logic uns,
                       output logic [31:0] o_rdata, output logic o_mis,
                       output int o_nvalid, output int o_nwe, output int o_rcyc, output int o_readyhi,
                       output logic [31:0] o_waddr, output logic [31:0] o_raddr,
                       output logic [31:0] o_wdata, output logic [3:0] o_mask);
        o_rdata = '0; o_mis = 1'b0; o_nvalid = 0; o_nwe = 0; o_rcyc = 0; o_readyhi = 0;
        o_waddr = '0; o_raddr = '0; o_wdata = '0; o_mask = '0;
        @(negedge clk);
        check($sformatf("d%0d_ready_idle", d), 32'(req_ready[d]), 32'h1);
        req_write[d] = wr; req_addr[d] = addr; req_wdata[d] = wd;
        req_size[d] = sz; req_unsigned[d] = uns; req_valid[d] = 1'b1;
        @(posedge clk);
        #1 req_valid[d] = 1'b0;
        req_addr[d] = $urandom;
        for (int k = 1; k <= 40 && o_rcyc == 0; k++) begin
            @(negedge clk);
            if (req_ready[d]) o_readyhi++;
            if (mem_valid[d]) begin
                if (o_nvalid == 0) begin
                    o_waddr = mem_waddr[d]; o_raddr = mem_raddr[d];
                    o_wdata = mem_wdata[d]; o_mask = mem_mask[d];
                end
                o_nvalid++;
            end
            if (mem_we[d]) o_nwe++;
            if (resp_valid[d]) begin
                o_rcyc = k; o_rdata = resp_rdata[d]; o_mis = resp_misalign[d];
            end
        end
        if (o_rcyc == 0) begin
            check($sformatf("d%0d_resp_timeout", d), 32'h0, 32'h1);
        end else begin
            @(negedge clk);
            check($sformatf("d%0d_resp_one_cycle", d), 32'(resp_valid[d]), 32'h0);
        end
    endtask

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wd;
        logic [1:0]  sz;
        logic        uns;
        logic [31:0] ramw;
        logic        mis;
        logic [31:0] rd;
        logic [31:0] maddr;
        logic [31:0] mwd;
        logic [3:0]  mask;
    } vec_t;

    vec_t tbl [10];

    initial begin
        logic [31:0] rd, waddr, raddr, wdat;
        logic        mis, emis;
        logic [31:0] erd;
        logic [3:0]  mask;
        int nvalid, nwe, rcyc, readyhi, lat, cnt;
        vec_t v;
        logic        rwr, runs;
        logic [1:0]  rsz;
        logic [31:0] raddr_r, rwd;

        tbl[0] = '{1'b1, 32'h80000004, 32'hDEADBEEF, 2'd2, 1'b0, 32'h0,       1'b0, 32'h0,        32'h80000004, 32'hDEADBEEF, 4'b1111};
        tbl[1] = '{1'b1, 32'h80000003, 32'h000000A5, 2'd0, 1'b0, 32'h0,       1'b0, 32'h0,        32'h80000000, 32'hA5000000, 4'b1000};
        tbl[2] = '{1'b0, 32'h80000002, 32'h0,        2'd0, 1'b0, 32'h12F45678, 1'b0, 32'hFFFFFFF4, 32'h80000000, 32'h0,        4'b0100};
        tbl[3] = '{1'b0, 32'h80000002, 32'h0,        2'd0, 1'b1, 32'h12F45678, 1'b0, 32'h000000F4, 32'h80000000, 32'h0,        4'b0100};
        tbl[4] = '{1'b0, 32'h80000002, 32'h0,        2'd1, 1'b0, 32'h80015678, 1'b0, 32'hFFFF8001, 32'h80000000, 32'h0,        4'b1100};
        tbl[5] = '{1'b0, 32'h80000001, 32'h0,        2'd1, 1'b0, 32'h80015678, 1'b1, 32'h0,        32'h0,        32'h0,        4'b0000};
        tbl[6] = '{1'b1, 32'h80000002, 32'h12345678, 2'd2, 1'b0, 32'h0,       1'b1, 32'h0,        32'h0,        32'h0,        4'b0000};
        tbl[7] = '{1'b0, 32'h80000000, 32'h0,        2'd3, 1'b0, 32'h0,       1'b1, 32'h0,        32'h0,        32'h0,        4'b0000};
        tbl[8] = '{1'b0, 32'h80000000, 32'h0,        2'd1, 1'b1, 32'h80015678, 1'b0, 32'h00005678, 32'h80000000, 32'h0,        4'b0011};
        tbl[9] = '{1'b0, 32'h80000008, 32'h0,        2'd2, 1'b0, 32'hCAFEF00D, 1'b0, 32'hCAFEF00D, 32'h80000008, 32'h0,        4'b1111};

        for (int d = 0; d < 2; d++) begin
            rst[d] = 1'b1; req_valid[d] = 1'b0; req_write[d] = 1'b0; req_addr[d] = '0;
            req_wdata[d] = '0; req_size[d] = '0; req_unsigned[d] = 1'b0;
        end
        #2;
        for (int d = 0; d < 2; d++) begin
            check($sformatf("d%0d_rst_ready", d), 32'(req_ready[d]), 32'h1);
            check($sformatf("d%0d_rst_mem_valid", d), 32'(mem_valid[d]), 32'h0);
            check($sformatf("d%0d_rst_we", d), 32'(mem_we[d]), 32'h0);
            check($sformatf("d%0d_rst_resp_valid", d), 32'(resp_valid[d]), 32'h0);
            check($sformatf("d%0d_rst_rdata", d), resp_rdata[d], 32'h0);
            check($sformatf("d%0d_rst_misalign", d), 32'(resp_misalign[d]), 32'h0);
            check($sformatf("d%0d_rst_addr", d), mem_waddr[d] | mem_raddr[d], 32'h0);
            check($sformatf("d%0d_rst_wdata_mask", d), mem_wdata[d] | 32'(mem_mask[d]), 32'h0);
        end
        @(negedge clk);
        rst[0] = 1'b0; rst[1] = 1'b0;

        for (int d = 0; d < 2; d++)
            for (int w = 0; w < 16; w++) set_word(d, w, $urandom);

        // Directed vectors on both latencies.
        for (int d = 0; d < 2; d++) begin
            lat = (d == 0) ? int'(LAT0) : int'(LAT1);
            for (int i = 0; i < 10; i++) begin
                v = tbl[i];
                set_word(d, int'(v.addr[5:2]), v.ramw);
                txn(d, v.wr, v.addr, v.wd, v.sz, v.uns, rd, mis, nvalid, nwe, rcyc, readyhi, waddr, raddr, wdat, mask);
                ref_txn(d, v.wr, v.addr, v.wd, v.sz, v.uns, emis, erd);
                check($sformatf("d%0d_v%0d_misalign", d, i), 32'(mis), 32'(v.mis));
                check($sformatf("d%0d_v%0d_rdata", d, i), rd, v.rd);
                check($sformatf("d%0d_v%0d_valid_cycles", d, i), nvalid, v.mis ? 0 : lat);
                check($sformatf("d%0d_v%0d_write_strobes", d, i), nwe, (v.wr && !v.mis) ? 1 : 0);
                check($sformatf("d%0d_v%0d_resp_cycle", d, i), rcyc, v.mis ? 1 : lat + 1);
                check($sformatf("d%0d_v%0d_ready_busy", d, i), readyhi, 0);
                check($sformatf("d%0d_v%0d_waddr", d, i), waddr, v.maddr);
                check($sformatf("d%0d_v%0d_raddr", d, i), raddr, v.maddr);
                check($sformatf("d%0d_v%0d_wdata", d, i), wdat, v.mwd);
                check($sformatf("d%0d_v%0d_mask", d, i), 32'(mask), 32'(v.mask));
            end
        end

        // Reset during the second ACCESS cycle of a latency-4 store.
        set_word(1, 0, 32'h11111111);
        @(negedge clk);
        req_write[1] = 1'b1; req_addr[1] = 32'h80000000; req_wdata[1] = 32'hCAFEBABE;
        req_size[1] = 2'd2; req_unsigned[1] = 1'b0; req_valid[1] = 1'b1;
        @(posedge clk);
        #1 req_valid[1] = 1'b0;
        @(negedge clk);
        check("rst_mid_access_started", 32'(mem_valid[1]), 32'h1);
        @(posedge clk);
        #1 rst[1] = 1'b1;
        #1;
        check("rst_mid_mem_valid", 32'(mem_valid[1]), 32'h0);
        check("rst_mid_we", 32'(mem_we[1]), 32'h0);
        check("rst_mid_resp_valid", 32'(resp_valid[1]), 32'h0);
        check("rst_mid_ready", 32'(req_ready[1]), 32'h1);
        @(negedge clk);
        @(negedge clk);
        rst[1] = 1'b0;
        cnt = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (mem_valid[1] || mem_we[1] || resp_valid[1]) cnt++;
        end
        check("rst_mid_no_activity", cnt, 0);
        txn(1, 1'b0, 32'h80000000, 32'h0, 2'd2, 1'b0, rd, mis, nvalid, nwe, rcyc, readyhi, waddr, raddr, wdat, mask);
        ref_txn(1, 1'b0, 32'h80000000, 32'h0, 2'd2, 1'b0, emis, erd);
        check("rst_mid_no_write", rd, erd);

        // Random traffic against the reference memory.
        for (int d = 0; d < 2; d++) begin
            lat = (d == 0) ? int'(LAT0) : int'(LAT1);
            for (int i = 0; i < 80; i++) begin
                rwr = 1'($urandom_range(0, 1));
                raddr_r = 32'h80000000 | 32'($urandom_range(0, 63));
                rsz = 2'($urandom_range(0, 3));
                runs = 1'($urandom_range(0, 1));
                rwd = $urandom;
                txn(d, rwr, raddr_r, rwd, rsz, runs, rd, mis, nvalid, nwe, rcyc, readyhi, waddr, raddr, wdat, mask);
                ref_txn(d, rwr, raddr_r, rwd, rsz, runs, emis, erd);
                check($sformatf("d%0d_r%0d_misalign", d, i), 32'(mis), 32'(emis));
                check($sformatf("d%0d_r%0d_rdata", d, i), rd, erd);
                check($sformatf("d%0d_r%0d_resp_cycle", d, i), rcyc, emis ? 1 : lat + 1);
                check($sformatf("d%0d_r%0d_write_strobes", d, i), nwe, (rwr && !emis) ? 1 : 0);
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
